// File: rtl/fir_tap_product_stage_if.sv
// Sample/coefficient/product bundle between the FIR front end and the tap product stage.
// Latency and flow are set by the stage; this bus has no handshake beyond the valid strobes.
interface fir_tap_product_stage_if #(
   parameter int SAMPLE_W = 11,
   parameter int COEF_W   = 8
);
   localparam int PROD_W = SAMPLE_W + COEF_W;

   logic signed [SAMPLE_W-1:0] sample_in;
   logic                       sample_valid;
   logic                       coef_wr_en;
   logic [2:0]                 coef_addr;
   logic signed [COEF_W-1:0]   coef_data;
   logic                       clear;
   logic signed [PROD_W-1:0]   prod_0;
   logic signed [PROD_W-1:0]   prod_1;
   logic signed [PROD_W-1:0]   prod_2;
   logic signed [PROD_W-1:0]   prod_3;
   logic signed [PROD_W-1:0]   prod_4;
   logic signed [PROD_W-1:0]   prod_5;
   logic signed [PROD_W-1:0]   prod_6;
   logic signed [PROD_W-1:0]   prod_7;
   logic                       prod_valid;
   logic                       primed;

   modport master (
      output sample_in, sample_valid, coef_wr_en, coef_addr, coef_data, clear,
      input  prod_0, prod_1, prod_2, prod_3, prod_4, prod_5, prod_6, prod_7,
      input  prod_valid, primed
   );

   modport slave (
      input  sample_in, sample_valid, coef_wr_en, coef_addr, coef_data, clear,
      output prod_0, prod_1, prod_2, prod_3, prod_4, prod_5, prod_6, prod_7,
      output prod_valid, primed
   );
endinterface

// File: rtl/fir_tap_product_stage.sv
// 8-tap delay line times programmable coefficients, feeding the 19-bit adder tree.
// Products registered 1 cycle after an accepted sample; no backpressure (tree always ready).
module fir_tap_product_stage #(
   parameter int SAMPLE_W = 11,
   parameter int COEF_W   = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   fir_tap_product_stage_if.slave bus
);
   localparam int PROD_W = SAMPLE_W + COEF_W;
   localparam int NTAP   = 8;

   if (PROD_W != 19) begin : g_width_check
      $error("fir_tap_product_stage: SAMPLE_W + COEF_W must equal 19");
   end

   // Only taps 0..6 are stored: tap 7 is consumed by the product register and then discarded.
   logic signed [SAMPLE_W-1:0] tap_q     [NTAP-1];
   logic signed [SAMPLE_W-1:0] next_tap  [NTAP];
   logic signed [COEF_W-1:0]   coef_q    [NTAP];
   logic signed [PROD_W-1:0]   prod_q    [NTAP];
   logic signed [PROD_W-1:0]   prod_next [NTAP];
   logic                       prod_valid_q;
   logic                       primed_q;
   logic [3:0]                 count_q;
   logic [3:0]                 count_next;
   logic                       accept;

   assign accept     = bus.sample_valid && !bus.clear;
   assign count_next = (count_q == 4'd8) ? count_q : count_q + 4'd1;

   // Sign-extend both operands to the product width so the low bits are the exact signed product.
   always_comb begin
      next_tap[0] = bus.sample_in;
      for (int k = 1; k < NTAP; k++) next_tap[k] = tap_q[k-1];
      for (int k = 0; k < NTAP; k++) begin
         prod_next[k] = {{COEF_W{next_tap[k][SAMPLE_W-1]}}, next_tap[k]}
                      * {{SAMPLE_W{coef_q[k][COEF_W-1]}}, coef_q[k]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAP-1; k++) tap_q[k] <= '0;
         for (int k = 0; k < NTAP; k++)   prod_q[k] <= '0;
         prod_valid_q <= 1'b0;
         primed_q     <= 1'b0;
         count_q      <= 4'd0;
      end else if (bus.clear) begin
         for (int k = 0; k < NTAP-1; k++) tap_q[k] <= '0;
         for (int k = 0; k < NTAP; k++)   prod_q[k] <= '0;
         prod_valid_q <= 1'b0;
         primed_q     <= 1'b0;
         count_q      <= 4'd0;
      end else if (accept) begin
         for (int k = 0; k < NTAP-1; k++) tap_q[k] <= next_tap[k];
         for (int k = 0; k < NTAP; k++)   prod_q[k] <= prod_next[k];
         prod_valid_q <= 1'b1;
         primed_q     <= (count_next == 4'd8);
         count_q      <= count_next;
      end else begin
         prod_valid_q <= 1'b0;
      end
   end

   // Coefficient writes are independent of clear; products at this edge still see the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAP; k++) coef_q[k] <= '0;
      end else if (bus.coef_wr_en) begin
         coef_q[bus.coef_addr] <= bus.coef_data;
      end
   end

   assign bus.prod_0     = prod_q[0];
   assign bus.prod_1     = prod_q[1];
   assign bus.prod_2     = prod_q[2];
   assign bus.prod_3     = prod_q[3];
   assign bus.prod_4     = prod_q[4];
   assign bus.prod_5     = prod_q[5];
   assign bus.prod_6     = prod_q[6];
   assign bus.prod_7     = prod_q[7];
   assign bus.prod_valid = prod_valid_q;
   assign bus.primed     = primed_q;
endmodule

// File: tb/tb_fir_tap_product_stage.sv
// Self-checking bench: impulse vector table, extremes, same-edge coef write, clear and async reset,
// with a reference delay-line model feeding a scoreboard queue.
module tb_fir_tap_product_stage;
   logic clk;
   logic rst_n;

   fir_tap_product_stage_if #(.SAMPLE_W(11), .COEF_W(8)) bus ();

   fir_tap_product_stage #(.SAMPLE_W(11), .COEF_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int p[8];
      bit primed;
   } exp_t;

   typedef struct {
      int sample;
      int exp_idx;
      int exp_val;
      bit exp_primed;
   } vec_t;

   exp_t sb_q[$];
   int   m_tap[8];
   int   m_coef[8];
   int   m_hold[8];
   int   m_count;
   int   n_total;
   int   n_pass;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int prod_of(input int k);
      case (k)
         0: return int'(bus.prod_0);
         1: return int'(bus.prod_1);
         2: return int'(bus.prod_2);
         3: return int'(bus.prod_3);
         4: return int'(bus.prod_4);
         5: return int'(bus.prod_5);
         6: return int'(bus.prod_6);
         default: return int'(bus.prod_7);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_tap[k]  = 0;
         m_coef[k] = 0;
         m_hold[k] = 0;
      end
      m_count = 0;
      sb_q.delete();
   endtask

   // One clock: drive inputs, advance the model, then check the DUT 1 time unit after the edge.
   task automatic step(input bit v, input int s, input bit we, input int a, input int d, input bit clr);
      exp_t e;
      bit   acc;
      bus.sample_valid = v;
      bus.sample_in    = 11'(s);
      bus.coef_wr_en   = we;
      bus.coef_addr    = 3'(a);
      bus.coef_data    = 8'(d);
      bus.clear        = clr;
      #1;
      if (v) chk("sample_in_known", int'($isunknown(bus.sample_in)), 0);
      acc = v && !clr;
      if (clr) begin
         for (int k = 0; k < 8; k++) begin
            m_tap[k]  = 0;
            m_hold[k] = 0;
         end
         m_count = 0;
      end else if (acc) begin
         for (int k = 7; k > 0; k--) m_tap[k] = m_tap[k-1];
         m_tap[0] = s;
         if (m_count < 8) m_count++;
         for (int k = 0; k < 8; k++) e.p[k] = m_tap[k] * m_coef[k];
         e.primed = (m_count == 8);
         sb_q.push_back(e);
         m_hold = e.p;
      end
      if (we) m_coef[a] = d;
      @(posedge clk);
      #1;
      chk("prod_valid", int'(bus.prod_valid), int'(acc));
      if (bus.prod_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            for (int k = 0; k < 8; k++) chk($sformatf("sb_prod_%0d", k), prod_of(k), e.p[k]);
            chk("sb_primed", int'(bus.primed), int'(e.primed));
         end
      end else begin
         for (int k = 0; k < 8; k++) chk($sformatf("hold_prod_%0d", k), prod_of(k), m_hold[k]);
         chk("hold_primed", int'(bus.primed), int'(m_count == 8));
      end
      bus.sample_valid = 1'b0;
      bus.coef_wr_en   = 1'b0;
      bus.clear        = 1'b0;
   endtask

   task automatic chk_all_zero(input string nm);
      for (int k = 0; k < 8; k++) chk($sformatf("%s_prod_%0d", nm, k), prod_of(k), 0);
      chk({nm, "_valid"}, int'(bus.prod_valid), 0);
      chk({nm, "_primed"}, int'(bus.primed), 0);
   endtask

   initial begin
      vec_t vecs[8];
      int   sum;
      n_total = 0;
      n_pass  = 0;
      model_reset();
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      bus.coef_wr_en   = 1'b0;
      bus.coef_addr    = '0;
      bus.coef_data    = '0;
      bus.clear        = 1'b0;
      #12 rst_n = 1'b1;

      // Reset then idle.
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
      chk_all_zero("reset_idle");

      // Impulse of 100 through coefficients 1..8.
      for (int k = 0; k < 8; k++) step(0, 0, 1, k, k + 1, 0);
      for (int j = 1; j <= 8; j++) begin
         vecs[j-1].sample     = (j == 1) ? 100 : 0;
         vecs[j-1].exp_idx    = j - 1;
         vecs[j-1].exp_val    = 100 * j;
         vecs[j-1].exp_primed = (j == 8);
      end
      for (int i = 0; i < 8; i++) begin
         step(1, vecs[i].sample, 0, 0, 0, 0);
         sum = 0;
         for (int k = 0; k < 8; k++) begin
            sum += prod_of(k);
            chk($sformatf("impulse%0d_prod_%0d", i, k), prod_of(k),
                (k == vecs[i].exp_idx) ? vecs[i].exp_val : 0);
         end
         chk($sformatf("impulse%0d_sum", i), sum, vecs[i].exp_val);
         chk($sformatf("impulse%0d_primed", i), int'(bus.primed), int'(vecs[i].exp_primed));
      end

      // Extremes.
      for (int k = 0; k < 8; k++) step(0, 0, 1, k, -128, 0);
      for (int i = 0; i < 8; i++) step(1, -1024, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("neg_ext_prod_%0d", k), prod_of(k), 131072);
      for (int k = 0; k < 8; k++) step(0, 0, 1, k, 127, 0);
      for (int i = 0; i < 8; i++) step(1, 1023, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("pos_ext_prod_%0d", k), prod_of(k), 129921);

      // Coefficient write on the same edge as a sample uses the old coefficient.
      step(0, 0, 1, 0, 5, 0);
      step(1, 10, 1, 0, 9, 0);
      chk("same_edge_old_coef", prod_of(0), 50);
      step(1, 10, 0, 0, 0, 0);
      chk("same_edge_new_coef", prod_of(0), 90);

      // Clear beats a simultaneous sample; a simultaneous coef write still lands.
      for (int i = 0; i < 8; i++) step(1, i + 1, 0, 0, 0, 0);
      chk("pre_clear_primed", int'(bus.primed), 1);
      step(1, 77, 1, 1, -3, 1);
      chk_all_zero("clear");
      step(1, 3, 0, 0, 0, 0);
      chk("post_clear_prod_0", prod_of(0), 27);
      for (int k = 1; k < 8; k++) chk($sformatf("post_clear_prod_%0d", k), prod_of(k), 0);
      step(1, 0, 0, 0, 0, 0);
      chk("clear_coef_write_kept", prod_of(1), -9);

      // Asynchronous reset between edges, mid-burst.
      step(1, 50, 0, 0, 0, 0);
      step(1, 60, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 100 + i, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_coef0_prod_%0d", k), prod_of(k), 0);
      step(0, 0, 1, 0, 2, 0);
      step(1, 5, 0, 0, 0, 0);
      chk("post_rst_prod_0", prod_of(0), 10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
